// File: rtl/interposer_pkg.sv
// Shared constants and types for the interposer ring arbiter.
// Control encodings, request field layout and controller state enum.
package interposer_pkg;

    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] CTRL_GRANT  = 3'b100;
    localparam logic [CTRL_W-1:0] CTRL_RECV   = 3'b010;
    localparam logic [CTRL_W-1:0] CTRL_BYPASS = 3'b001;
    localparam logic [CTRL_W-1:0] CTRL_IDLE   = 3'b000;

    // Each request slice is {valid, dest_id}: dest in the low bits, valid on top.
    localparam int REQ_DEST_LSB = 0;

    function automatic int req_valid_pos(input int id_w);
        return id_w;
    endfunction

    localparam int MSG_W = 22;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_TRANSFER,
        ST_RELEASE
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority select: first valid index at or above ptr, wrapping.
// N must be a power of two so the index wraps by natural overflow.
module rr_picker #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] k;

    // Scan from the far end down so the closest candidate is assigned last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = ptr + W'(i);
            if (valid[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    end

endmodule

// File: rtl/interposer_arbiter.sv
// Ring bus controller: round-robin sender selection and per-node
// GRANT/RECEIVE/BYPASS control sequencing, one transaction at a time.
module interposer_arbiter
    import interposer_pkg::*;
#(
    parameter int NUM_NODES   = 8,
    parameter int ID_W        = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_NODES*(ID_W+1)-1:0] req_in,
    output logic [NUM_NODES*CTRL_W-1:0]   control_out,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id,
    output logic                          req_err
);

    localparam int RW = ID_W + 1;
    localparam int VB = req_valid_pos(ID_W);
    localparam int CW = 4;

    state_e              state;
    logic [CW-1:0]       cnt;
    logic [ID_W-1:0]     src;
    logic [ID_W-1:0]     dst;
    logic [ID_W-1:0]     rr_ptr;

    logic [NUM_NODES-1:0] valid_vec;
    logic [ID_W-1:0]      dest_arr [NUM_NODES];
    logic                 pick_found;
    logic [ID_W-1:0]      pick_idx;
    logic [ID_W-1:0]      pick_dst;
    logic                 pick_ok;
    logic [NUM_NODES-1:0] bypass_mask;
    logic [NUM_NODES*CTRL_W-1:0] ctrl_nxt;

    always_comb begin
        for (int i = 0; i < NUM_NODES; i++) begin
            valid_vec[i] = req_in[i*RW+VB];
            dest_arr[i]  = req_in[i*RW+REQ_DEST_LSB +: ID_W];
        end
    end

    rr_picker #(
        .N (NUM_NODES),
        .W (ID_W)
    ) u_pick (
        .valid (valid_vec),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_dst = dest_arr[pick_idx];
    assign pick_ok  = (pick_dst != pick_idx) &&
                      ({1'b0, pick_dst} < RW'(NUM_NODES));

    // Nodes strictly after s and before d walking upward around the ring.
    function automatic logic [NUM_NODES-1:0] seg_mask(
        input logic [ID_W-1:0] s,
        input logic [ID_W-1:0] d
    );
        logic [NUM_NODES-1:0] m;
        logic [ID_W-1:0]      p;
        logic                 hit;
        m   = '0;
        hit = 1'b0;
        for (int k = 1; k < NUM_NODES; k++) begin
            p = s + ID_W'(k);
            if (p == d) hit = 1'b1;
            if (!hit) m[p] = 1'b1;
        end
        return m;
    endfunction

    assign bypass_mask = seg_mask(src, dst);

    always_comb begin
        ctrl_nxt = '0;
        unique case (state)
            ST_GRANT: ctrl_nxt[src*CTRL_W +: CTRL_W] = CTRL_GRANT;
            ST_TRANSFER: begin
                for (int i = 0; i < NUM_NODES; i++) begin
                    ctrl_nxt[i*CTRL_W +: CTRL_W] =
                        bypass_mask[i] ? CTRL_BYPASS : CTRL_IDLE;
                end
                ctrl_nxt[dst*CTRL_W +: CTRL_W] = CTRL_RECV;
            end
            default: ctrl_nxt = '0;
        endcase
    end

    // Outputs are registered images of the state one cycle behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            src         <= '0;
            dst         <= '0;
            rr_ptr      <= '0;
            control_out <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            req_err     <= 1'b0;
        end else begin
            control_out <= ctrl_nxt;
            busy        <= (state != ST_IDLE);
            req_err     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        rr_ptr <= pick_idx + ID_W'(1);
                        if (pick_ok) begin
                            src   <= pick_idx;
                            dst   <= pick_dst;
                            state <= ST_GRANT;
                        end else begin
                            req_err <= 1'b1;
                        end
                    end
                end
                ST_GRANT: begin
                    grant_id <= src;
                    cnt      <= CW'(HOLD_CYCLES);
                    state    <= ST_TRANSFER;
                end
                ST_TRANSFER: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= ST_RELEASE;
                end
                ST_RELEASE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/interposer_arbiter.md
# interposer_arbiter

Central bus controller for the multipoint interposer ring. It collects the 4-bit send requests from every NodeIO instance and selects one sender per transaction by round-robin. It then drives each node's 3-bit control input: GRANT to the sender, RECEIVE to the destination, BYPASS to every node strictly between them along the ring, and IDLE to all others. It is the responder end of the NodeIO request/control handshake and sits at the top level beside the node array.

## Interface
- NUM_NODES, 8, number of ring nodes; power of two, 2..16
- ID_W, 3, node id width, equal to log2(NUM_NODES)
- HOLD_CYCLES, 2, cycles RECEIVE/BYPASS stay asserted per transaction; range 1..15
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; all state and outputs cleared
- req_in  in  NUM_NODES*(ID_W+1)  per node i, slice [i*(ID_W+1) +: ID_W+1] = {valid, dest_id}
- control_out  out  NUM_NODES*3  per node i, slice [i*3 +: 3]: 3'b100 GRANT, 3'b010 RECEIVE, 3'b001 BYPASS, 3'b000 IDLE
- busy  out  1  high in any state other than IDLE
- grant_id  out  ID_W  id of current or most recent sender
- req_err  out  1  one-cycle pulse when a selected request was illegal and dropped

## Operation
- States: IDLE, GRANT, TRANSFER, RELEASE.
- IDLE: round-robin pick among nodes with valid=1. Search starts at rr_ptr and proceeds upward, wrapping mod NUM_NODES.
  - Legal pick (dest != source, dest < NUM_NODES): latch src/dst, set rr_ptr = src+1 mod NUM_NODES, go to GRANT.
  - Illegal pick: pulse req_err, set rr_ptr = src+1, stay IDLE.
  - No request: stay IDLE.
- GRANT (1 cycle): control_out[src]=GRANT, all others IDLE.
- TRANSFER (HOLD_CYCLES cycles, counted by a down-counter):
  - control_out[dst]=RECEIVE.
  - Nodes (src+1 .. dst-1) mod NUM_NODES = BYPASS; this covers wrap-around.
  - src and all remaining nodes IDLE.
- RELEASE (1 cycle): all IDLE, so the sender can drop its request. Then go to IDLE.
- Requests are sampled only in IDLE. Request changes during a transaction are ignored.
- Only one transaction is in flight at a time.
- Every control slice is always one-hot or zero. Never more than one GRANT or RECEIVE.

## Timing
- All outputs are registered.
- Reset values: control_out=0, busy=0, grant_id=0, req_err=0, rr_ptr=0, state=IDLE, counter=0.
- A request sampled in IDLE at edge T produces GRANT visible after edge T+1.
- RECEIVE/BYPASS are visible after edges T+2 .. T+1+HOLD_CYCLES. RELEASE follows, then IDLE.
- Transaction length is HOLD_CYCLES+2 cycles. The next grant is visible at the earliest 1 cycle after RELEASE ends.
- req_err is asserted the cycle after the illegal request is sampled.
- Reset mid-transaction: the next cycle has all controls 0, state IDLE, rr_ptr=0. No partial RECEIVE is retained.
- With simultaneous requests, the node closest to rr_ptr going upward wins. A sender cannot win twice consecutively while another node is waiting.

## Structure
- Package interposer_pkg holds:
  - CTRL_GRANT/CTRL_RECV/CTRL_BYPASS/CTRL_IDLE constants
  - request field positions (valid bit, dest field)
  - state enum
  - message width constant MSG_W=22
- Sub-module rr_picker: combinational round-robin priority select. Inputs are the valid vector and rr_ptr; outputs are found and index.
- Ring-segment BYPASS mask: one combinational function in the top module, evaluated on latched src/dst.

## Test plan
- Reset, then node0 req {1,3'b110}: node0=100 one cycle; then 2 cycles node6=010, nodes1–5=001, node7=000; then all 000 one cycle; busy high 4 cycles.
- Wrap-around: node6 req dest 1 → node6 GRANT, then node1 RECEIVE, nodes7,0 BYPASS, nodes2–5 IDLE.
- Contention: rr_ptr=3, nodes2 and 5 request simultaneously → node5 served first, node2 immediately after; grant_id 5 then 2.
- Illegal: node3 req {1,3'b011} alone → req_err pulses one cycle, control_out stays 0, rr_ptr becomes 4.
- Adjacent: node4 → node5 → no BYPASS anywhere; node5=010 for HOLD_CYCLES cycles.
- Reset asserted during second TRANSFER cycle → next cycle control_out=0, busy=0; a fresh request from node7 is then granted normally.
